// File: rtl/lsu_ld_ctrl.sv
// Load controller: accepts one load at a time, checks alignment, issues a
// word-aligned read with req/gnt handshake, then extracts and extends the
// requested byte/halfword/word for register writeback.
module lsu_ld_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [2:0]  ld_op,
  input  logic [31:0] ld_addr,
  input  logic [4:0]  ld_rd,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        ale,
  output logic        buserr,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_RESP} state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] off;
    logic [4:0] rd;
  } ld_cmd_t;

  // The timeout fires on the cycle whose increment brings the counter to
  // TIMEOUT-1, so buserr lands TIMEOUT cycles after the grant cycle.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 2);

  state_t          state, state_nxt;
  ld_cmd_t         cmd_q;
  logic [TO_W-1:0] cnt;
  logic            acc, bad, legal, misal, to_hit, do_buserr, capture;
  logic [7:0]      byte_l;
  logic [15:0]     half_l;
  logic [31:0]     ext;

  assign ld_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign mem_req  = (state == S_REQ);
  assign wb_valid = (state == S_RESP);

  // Decode the incoming command: legality and natural alignment.
  always_comb begin
    legal = 1'b1;
    misal = 1'b0;
    case (ld_op)
      3'b000, 3'b100: misal = 1'b0;
      3'b001, 3'b101: misal = ld_addr[0];
      3'b010:         misal = |ld_addr[1:0];
      default:        legal = 1'b0;
    endcase
    acc = (state == S_IDLE) && ld_valid && !flush;
    bad = !legal || misal;
  end

  assign to_hit    = (cnt == TO_LAST);
  assign do_buserr = (state == S_WAIT) && !mem_rvalid && !flush && to_hit;
  assign capture   = (state == S_WAIT) && mem_rvalid && !flush;

  // Little-endian lane select and sign/zero extension of the returned word.
  always_comb begin
    byte_l = mem_rdata[{cmd_q.off, 3'b000} +: 8];
    half_l = mem_rdata[{cmd_q.off[1], 4'b0000} +: 16];
    case (cmd_q.op)
      3'b000:  ext = {{24{byte_l[7]}}, byte_l};
      3'b100:  ext = {24'b0, byte_l};
      3'b001:  ext = {{16{half_l[15]}}, half_l};
      3'b101:  ext = {16'b0, half_l};
      default: ext = mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; flush priority depends on whether the read was issued.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (acc && !bad) state_nxt = S_REQ;
      S_REQ: begin
        if (mem_gnt)    state_nxt = flush ? S_DRAIN : S_WAIT;
        else if (flush) state_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (mem_rvalid)  state_nxt = flush ? S_IDLE : S_RESP;
        else if (flush)  state_nxt = S_DRAIN;
        else if (to_hit) state_nxt = S_DRAIN;
      end
      S_DRAIN: if (mem_rvalid) state_nxt = S_IDLE;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command latch, timeout counter, exception pulses and writeback data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q    <= '0;
      mem_addr <= '0;
      cnt      <= '0;
      ale      <= 1'b0;
      buserr   <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      ale    <= acc && bad;
      buserr <= do_buserr;
      if (acc) begin
        cmd_q    <= '{op: ld_op, off: ld_addr[1:0], rd: ld_rd};
        mem_addr <= {ld_addr[31:2], 2'b00};
      end
      if (state == S_REQ && mem_gnt) cnt <= '0;
      else if (state == S_WAIT)      cnt <= cnt + 1'b1;
      if (capture) begin
        wb_data <= ext;
        wb_rd   <= cmd_q.rd;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ld_ctrl.sv
// Directed bench for lsu_ld_ctrl: table of loads against a fixed memory
// word, plus hand sequences for misalignment, grant stall, flush, timeout
// and asynchronous reset.
module tb_lsu_ld_ctrl;

  localparam logic [31:0] WORD = 32'h80a55a7f;
  localparam logic [31:0] BASE = 32'h1c001000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid, ld_ready, flush;
  logic [2:0]  ld_op;
  logic [31:0] ld_addr;
  logic [4:0]  ld_rd;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_rdata;
  logic        wb_valid, ale, buserr, busy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int npass = 0;
  int ntot  = 0;
  int cyc   = 0;

  lsu_ld_ctrl #(.TIMEOUT(8), .TO_W(7)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_op(ld_op),
    .ld_addr(ld_addr), .ld_rd(ld_rd), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .ale(ale), .buserr(buserr), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [4:0]  rd;
    int          gw;
    int          k;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Issue one load, grant after gw stall cycles, return data k cycles after grant.
  task automatic do_load(input vec_t v, input string nm);
    int acc_c, seen;
    @(negedge clk);
    ld_valid = 1'b1; ld_op = v.op; ld_addr = v.addr; ld_rd = v.rd; acc_c = cyc;
    @(negedge clk);
    ld_valid = 1'b0;
    chk({nm, " req"}, 32'(mem_req), 32'd1);
    chk({nm, " maddr"}, mem_addr, {v.addr[31:2], 2'b00});
    repeat (v.gw) @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    repeat (v.k - 1) @(negedge clk);
    mem_rdata = WORD; mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
    seen = -1;
    for (int i = 0; i < 8; i++) begin
      if (wb_valid) begin seen = cyc; break; end
      @(negedge clk);
    end
    chk({nm, " lat"}, (seen < 0) ? 32'hffffffff : 32'(seen - acc_c), 32'(v.exp_lat));
    chk({nm, " data"}, wb_data, v.exp_data);
    chk({nm, " rd"}, 32'(wb_rd), 32'(v.rd));
    @(negedge clk);
    chk({nm, " wb_once"}, 32'(wb_valid), 32'd0);
    chk({nm, " ready"}, 32'(ld_ready), 32'd1);
  endtask

  // Misaligned or illegal command: one ale pulse, no request, no writeback.
  task automatic do_ale(input logic [2:0] op, input logic [31:0] addr, input string nm);
    @(negedge clk);
    ld_valid = 1'b1; ld_op = op; ld_addr = addr; ld_rd = 5'd1;
    @(negedge clk);
    ld_valid = 1'b0;
    chk({nm, " ale"}, 32'(ale), 32'd1);
    chk({nm, " noreq"}, 32'(mem_req), 32'd0);
    chk({nm, " nowb"}, 32'(wb_valid), 32'd0);
    @(negedge clk);
    chk({nm, " ale_off"}, 32'(ale), 32'd0);
    chk({nm, " ready"}, 32'(ld_ready), 32'd1);
    chk({nm, " noreq2"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc_c, be_c;
    vec_t v;
    vt[0] = '{3'b000, BASE + 1, 5'd5,  0, 1, 32'h0000005a, 3};
    vt[1] = '{3'b000, BASE + 3, 5'd6,  0, 1, 32'hffffff80, 3};
    vt[2] = '{3'b100, BASE + 3, 5'd7,  0, 1, 32'h00000080, 3};
    vt[3] = '{3'b001, BASE + 2, 5'd8,  0, 1, 32'hffff80a5, 3};
    vt[4] = '{3'b101, BASE + 2, 5'd9,  0, 1, 32'h000080a5, 3};
    vt[5] = '{3'b010, BASE + 0, 5'd10, 0, 1, 32'h80a55a7f, 3};
    vt[6] = '{3'b001, BASE + 0, 5'd11, 0, 3, 32'h00005a7f, 5};
    vt[7] = '{3'b100, BASE + 0, 5'd12, 2, 2, 32'h0000007f, 6};
    vt[8] = '{3'b000, BASE + 2, 5'd31, 0, 1, 32'hffffffa5, 3};

    reset = 1'b1; ld_valid = 0; ld_op = 0; ld_addr = 0; ld_rd = 0;
    flush = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst req", 32'(mem_req), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst ready", 32'(ld_ready), 32'd1);
    chk("rst wb", {wb_valid, ale, buserr, wb_rd}, 32'd0);
    chk("rst data", wb_data, 32'd0);
    chk("rst maddr", mem_addr, 32'd0);
    reset = 1'b0;

    foreach (vt[i]) do_load(vt[i], $sformatf("v%0d", i));

    do_ale(3'b001, BASE + 1, "mis_h");
    do_ale(3'b010, BASE + 2, "mis_w");
    do_ale(3'b011, BASE + 0, "ill_op");

    // rvalid while idle is ignored
    @(negedge clk); mem_rvalid = 1'b1;
    @(negedge clk); mem_rvalid = 1'b0;
    chk("idle_rv busy", 32'(busy), 32'd0);
    chk("idle_rv wb", 32'(wb_valid), 32'd0);

    // grant stalled 4 cycles, then flush in WAIT; late rvalid drained
    @(negedge clk);
    ld_valid = 1'b1; ld_op = 3'b010; ld_addr = BASE + 4; ld_rd = 5'd3;
    @(negedge clk);
    ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stall%0d req", i), 32'(mem_req), 32'd1);
      chk($sformatf("stall%0d addr", i), mem_addr, BASE + 4);
      if (i < 3) @(negedge clk);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("stall req_drop", 32'(mem_req), 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl drain busy", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    chk("fl drain wb", 32'(wb_valid), 32'd0);
    chk("fl drain busy2", 32'(busy), 32'd1);
    mem_rvalid = 1'b1; mem_rdata = WORD;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("fl idle busy", 32'(busy), 32'd0);
    chk("fl idle wb", 32'(wb_valid), 32'd0);

    // flush in REQ without grant: back to IDLE with nothing issued
    @(negedge clk);
    ld_valid = 1'b1; ld_op = 3'b000; ld_addr = BASE; ld_rd = 5'd2;
    @(negedge clk);
    ld_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("req_fl busy", 32'(busy), 32'd0);
    chk("req_fl req", 32'(mem_req), 32'd0);

    // timeout: grant, no rvalid, buserr 8 cycles after grant
    @(negedge clk);
    ld_valid = 1'b1; ld_op = 3'b010; ld_addr = BASE; ld_rd = 5'd4; acc_c = cyc;
    @(negedge clk);
    ld_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    be_c = -1;
    for (int i = 0; i < 20; i++) begin
      if (buserr) begin be_c = cyc; break; end
      chk($sformatf("to wb%0d", i), 32'(wb_valid), 32'd0);
      @(negedge clk);
    end
    chk("to buserr_lat", (be_c < 0) ? 32'hffffffff : 32'(be_c - (acc_c + 1)), 32'd8);
    @(negedge clk);
    chk("to buserr_once", 32'(buserr), 32'd0);
    chk("to drain busy", 32'(busy), 32'd1);
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("to idle busy", 32'(busy), 32'd0);
    chk("to idle wb", 32'(wb_valid), 32'd0);

    // async reset while in WAIT
    @(negedge clk);
    ld_valid = 1'b1; ld_op = 3'b010; ld_addr = BASE; ld_rd = 5'd9;
    @(negedge clk);
    ld_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("arst pre busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst maddr", mem_addr, 32'd0);
    chk("arst out", {mem_req, wb_valid, ale, buserr}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    v = '{3'b100, BASE + 1, 5'd14, 0, 1, 32'h0000005a, 3};
    do_load(v, "post_rst");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
